// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the fetch and load/store paths.
// Each access: request/accept handshake in IDLE, MEM_LATENCY cycles of BUSY,
// then a one-cycle response pulse in RESP to the owner only.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned FIXED_PRIO  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_ready,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be in 1..15");
  end
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("mem_port_arbiter: DATA_W must be a multiple of 8");
  end

  localparam logic [3:0] LatM1 = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;
  typedef enum logic [1:0] {OwnNone, OwnIf, OwnD} owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                last_d_q, last_d_d;   // 1 = last grant went to data
  logic [3:0]          cnt_q, cnt_d;
  logic                first_q, first_d;     // first BUSY cycle, gates the write strobe
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic prio_if, grant_if, grant_d;

  // Tie-break: fetch wins when fixed priority is set or data was served last.
  always_comb begin
    prio_if  = (FIXED_PRIO != 0) || last_d_q;
    grant_if = (state_q == StIdle) && if_req && (!d_req || prio_if);
    grant_d  = (state_q == StIdle) && d_req && !grant_if;
  end

  // Next-state logic: grant and latch in IDLE, count latency in BUSY, respond in RESP.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d_d   = last_d_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_if) begin
          addr_d   = if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          wmask_d  = '0;
          owner_d  = OwnIf;
          last_d_d = 1'b0;
        end else if (grant_d) begin
          addr_d   = d_addr;
          we_d     = d_we;
          wdata_d  = d_wdata;
          wmask_d  = d_wmask;
          owner_d  = OwnD;
          last_d_d = 1'b1;
        end
        if (grant_if || grant_d) begin
          cnt_d   = LatM1;
          first_d = 1'b1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        first_d = 1'b0;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (owner_q == OwnIf) begin
            if_rdata_d = mem_rdata;
          end else begin
            d_rdata_d = we_q ? '0 : mem_rdata;
          end
          state_d = StResp;
        end
      end
      StResp: begin
        owner_d = OwnNone;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_q    <= OwnNone;
      last_d_q   <= 1'b1;
      cnt_q      <= 4'd0;
      first_q    <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_d_q   <= last_d_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Outputs, forced to 0 while reset is held so an in-flight access stops at once.
  always_comb begin
    if_ready  = rst_n && grant_if;
    d_ready   = rst_n && grant_d;
    if_rvalid = rst_n && (state_q == StResp) && (owner_q == OwnIf);
    d_rvalid  = rst_n && (state_q == StResp) && (owner_q == OwnD);
    if_rdata  = rst_n ? if_rdata_q : '0;
    d_rdata   = rst_n ? d_rdata_q : '0;
    mem_en    = rst_n && (state_q == StBusy);
    mem_we    = mem_en && first_q && we_q;
    mem_addr  = mem_en ? addr_q : '0;
    mem_wdata = mem_en ? wdata_q : '0;
    mem_wmask = mem_en ? wmask_q : '0;
  end

endmodule
